// File: rtl/pipelined_adder_tree.sv
// -----------------------------------------------------------------------------
// pipelined_adder_tree
//
// Pipelined signed adder tree with an optional multi-beat accumulator.
// Each accepted beat carries NUM_IN signed IN_W-bit lanes. They are summed
// pairwise through LEVELS = clog2(NUM_IN) registered tree levels. A final
// accumulator stage adds consecutive beats until a beat flagged in_last
// closes the group, and then presents the group sum on out_data.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_data    NUM_IN packed lanes, lane i at [(i+1)*IN_W-1 : i*IN_W]
//   in_valid   in_data / in_last valid
//   in_last    final beat of an accumulation group
//   in_ready   block accepts a beat this cycle (combinational)
//   out_data   signed OUT_W-bit group sum (registered)
//   out_valid  out_data valid (registered)
//   out_ready  downstream accepts out_data
//
// Build option:
//   SATURATE_EN  when defined, the accumulator clamps to the signed OUT_W
//                range instead of wrapping.
// -----------------------------------------------------------------------------
module pipelined_adder_tree #(
  parameter int NUM_IN = 16,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 24
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_IN*IN_W-1:0]         in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic signed [OUT_W-1:0]        out_data,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int LEVELS = $clog2(NUM_IN);
  // Widest tree value; every node is carried at this width between levels.
  localparam int TREE_W = IN_W + LEVELS;

  logic                     advance_s;
  logic                     accept_s;

  // Valid / last bits of stage 0 .. stage LEVELS, travelling with the data.
  logic [LEVELS:0]          vld_q;
  logic [LEVELS:0]          last_q;

  // Sign-extended view of every node register, [level][element].
  // Elements beyond the node count of a level are tied to zero.
  logic signed [TREE_W-1:0] node_s [LEVELS+1][NUM_IN];

  logic signed [OUT_W-1:0]  tree_ext_s;
  logic signed [OUT_W-1:0]  acc_base_s;
  logic signed [OUT_W-1:0]  acc_d;
  logic signed [OUT_W-1:0]  acc_q;
  logic signed [OUT_W-1:0]  out_data_q;
  logic                     out_valid_q;
  logic                     first_q;

`ifdef SATURATE_EN
  // Add at OUT_W+1 bits and clamp to the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_add(
    input logic signed [OUT_W-1:0] a,
    input logic signed [OUT_W-1:0] b
  );
    logic [OUT_W:0] wide;
    wide = {a[OUT_W-1], a} + {b[OUT_W-1], b};
    // The two top bits differ only when the true sum left the OUT_W range.
    if (wide[OUT_W] != wide[OUT_W-1]) begin
      if (wide[OUT_W]) begin
        sat_add = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin
      sat_add = wide[OUT_W-1:0];
    end
  endfunction
`endif

  // The whole pipeline moves together; it only stalls on a held output.
  assign advance_s = !out_valid_q || out_ready;
  assign in_ready  = advance_s;
  assign accept_s  = in_valid && advance_s;

  // Valid/last shift register; a non-accepted advancing cycle inserts a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (advance_s) begin
      vld_q  <= {vld_q[LEVELS-1:0], accept_s};
      last_q <= {last_q[LEVELS-1:0], accept_s && in_last};
    end else begin
      vld_q  <= vld_q;
      last_q <= last_q;
    end
  end

  // Stage 0: input lane registers.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    logic signed [IN_W-1:0] lane_q;

    // Capture a lane only on an accepted beat; bubbles leave stale data that
    // is never qualified by a valid bit downstream.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lane_q <= '0;
      end else if (accept_s) begin
        lane_q <= in_data[i*IN_W +: IN_W];
      end else begin
        lane_q <= lane_q;
      end
    end

    assign node_s[0][i] = TREE_W'(lane_q);
  end

  // Tree levels 1..LEVELS: level k holds NUM_IN>>k sums, each IN_W+k bits.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int W = IN_W + k;
    localparam int N = NUM_IN >> k;

    for (genvar j = 0; j < NUM_IN; j++) begin : g_node
      if (j < N) begin : g_sum
        logic signed [W-1:0] sum_d;
        logic signed [W-1:0] sum_q;

        // Operands fit in W-1 bits, so their low W bits add without overflow.
        assign sum_d = node_s[k-1][2*j][W-1:0] + node_s[k-1][2*j+1][W-1:0];

        // Pairwise sum register, held while the pipeline is stalled.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            sum_q <= '0;
          end else if (advance_s) begin
            sum_q <= sum_d;
          end else begin
            sum_q <= sum_q;
          end
        end

        assign node_s[k][j] = TREE_W'(sum_q);
      end else begin : g_pad
        assign node_s[k][j] = '0;
      end
    end
  end

  assign tree_ext_s = OUT_W'(node_s[LEVELS][0]);

  // Next accumulator value: the first beat of a group ignores the old sum.
  always_comb begin
    acc_base_s = '0;
    acc_d      = '0;
    if (first_q) begin
      acc_base_s = '0;
    end else begin
      acc_base_s = acc_q;
    end
`ifdef SATURATE_EN
    acc_d = sat_add(acc_base_s, tree_ext_s);
`else
    acc_d = acc_base_s + tree_ext_s;
`endif
  end

  // Accumulator and output register; a last beat publishes and restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b1;
    end else if (advance_s) begin
      if (vld_q[LEVELS]) begin
        if (last_q[LEVELS]) begin
          out_data_q  <= acc_d;
          out_valid_q <= 1'b1;
          first_q     <= 1'b1;
        end else begin
          acc_q       <= acc_d;
          out_valid_q <= 1'b0;
          first_q     <= 1'b0;
        end
      end else begin
        // Bubble: any pending result was taken (advance), so drop valid.
        out_valid_q <= 1'b0;
      end
    end else begin
      acc_q       <= acc_q;
      out_data_q  <= out_data_q;
      out_valid_q <= out_valid_q;
      first_q     <= first_q;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder_tree
//
// Self-checking bench for pipelined_adder_tree (default parameters).
// A behavioural model turns every accepted beat into a plain integer lane sum,
// accumulates it per group and queues the expected group result; results
// leaving the DUT are compared in order against that queue.
// -----------------------------------------------------------------------------
module tb_pipelined_adder_tree;

  localparam int NUM_IN = 16;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 24;
  localparam int LEVELS = 4;
  localparam int DW     = NUM_IN * IN_W;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [DW-1:0]           in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  always #5 clk = ~clk;

  pipelined_adder_tree #(
    .NUM_IN(NUM_IN),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint exp_q[$];
  int     hs_cyc[$];
  int     cyc = 0;
  longint grp_m = 0;
  bit     lat_probe = 1'b0;
  bit     lat_armed = 1'b0;
  int     lat_acc_cyc = 0;
  int     rdy_mode = 0;
  int     pat_i = 0;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] all_lanes(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < NUM_IN; i++) r[i*IN_W +: IN_W] = v[IN_W-1:0];
    return r;
  endfunction

  function automatic longint beat_sum(input logic [DW-1:0] d);
    longint s = 0;
    for (int i = 0; i < NUM_IN; i++) s += longint'($signed(d[i*IN_W +: IN_W]));
    return s;
  endfunction

  // Reference: integer group sum, clamped per beat or wrapped at the end.
  task automatic model_accept(input logic [DW-1:0] d, input logic l);
    longint        lo = -(longint'(1) << (OUT_W-1));
    longint        hi = (longint'(1) << (OUT_W-1)) - 1;
    longint        x;
    logic [OUT_W-1:0] t;
    grp_m += beat_sum(d);
`ifdef SATURATE_EN
    if (grp_m > hi) grp_m = hi;
    if (grp_m < lo) grp_m = lo;
`endif
    if (l) begin
      x = grp_m;
      t = x[OUT_W-1:0];
      exp_q.push_back(longint'($signed(t)));
      grp_m = 0;
    end
  endtask

  function automatic logic next_ready();
    logic r;
    case (rdy_mode)
      0:       r = 1'b1;
      1:       r = ((pat_i % 3) == 0);
      default: r = ($urandom_range(0, 3) != 0);
    endcase
    pat_i++;
    return r;
  endfunction

  // One clock cycle: drive, settle, observe what the next edge will do.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                       input logic ordy, output bit took);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    #1;
    check_val("in_ready", in_ready, !(out_valid && !out_ready));
    took = v && in_ready;
    if (took) model_accept(d, l);
    if (took && lat_probe) begin
      lat_acc_cyc = cyc;
      lat_armed   = 1'b1;
      lat_probe   = 1'b0;
    end else if (out_valid && lat_armed) begin
      check_val("latency", cyc - lat_acc_cyc, LEVELS + 2);
      lat_armed = 1'b0;
    end
    if (out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) check_val("spurious_out", out_valid, 0);
      else check_val("out_data", out_data, exp_q.pop_front());
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    bit took = 1'b0;
    for (int n = 0; n < 100 && !took; n++) cycle(1'b1, d, l, next_ready(), took);
    if (!took) check_val("accept_timeout", took, 1);
  endtask

  task automatic drain();
    bit t;
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) cycle(1'b0, '0, 1'b0, next_ready(), t);
    check_val("drain_left", exp_q.size(), 0);
    for (int n = 0; n < 4; n++) cycle(1'b0, '0, 1'b0, 1'b1, t);
  endtask

  task automatic do_reset(input int n);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    repeat (n) @(posedge clk);
    cyc += n;
    check_val("rst_hold_valid", out_valid, 0);
    #1;
    reset_n   = 1'b1;
    grp_m     = 0;
    exp_q.delete();
    lat_armed = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int  base;
    bit  t;
    logic [DW-1:0] rd;

    // 1. Reset and latency.
    do_reset(3);
    rdy_mode  = 0;
    lat_probe = 1'b1;
    send_beat(all_lanes(1), 1'b1);
    drain();
    check_val("latency_seen", lat_armed, 0);

    // 2. Signed extremes, back to back.
    base = hs_cyc.size();
    send_beat(all_lanes(-32768), 1'b1);
    send_beat(all_lanes(32767), 1'b1);
    drain();
    check_val("b2b_count", hs_cyc.size() - base, 2);
    if (hs_cyc.size() - base == 2) check_val("b2b_gap", hs_cyc[base+1] - hs_cyc[base], 1);

    // 3. Four-beat accumulation.
    base = hs_cyc.size();
    for (int b = 0; b < 4; b++) send_beat(all_lanes(1000), b == 3);
    drain();
    check_val("acc_count", hs_cyc.size() - base, 1);

    // 4. Backpressure with out_ready pattern 1,0,0,...
    rdy_mode = 1;
    pat_i    = 0;
    base     = hs_cyc.size();
    for (int k = 1; k <= 10; k++) send_beat(all_lanes(k), 1'b1);
    drain();
    check_val("bp_count", hs_cyc.size() - base, 10);
    rdy_mode = 0;

    // 5. Overflow in one long group.
    for (int b = 0; b < 40; b++) send_beat(all_lanes(32767), b == 39);
    drain();

    // 6. Reset mid-group discards the partial sum.
    send_beat(all_lanes(5), 1'b0);
    send_beat(all_lanes(5), 1'b0);
    do_reset(1);
    send_beat(all_lanes(2), 1'b1);
    drain();

    // Random traffic with random backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < DW / 32; w++) rd[w*32 +: 32] = $urandom;
      cycle($urandom_range(0, 3) != 0, rd, $urandom_range(0, 2) == 0, next_ready(), t);
    end
    send_beat(all_lanes(-3), 1'b1);
    rdy_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
